intr_controller: RTL and testbench

- Memory-mapped interrupt controller sitting directly downstream of the timer/counter and other peripherals.
- Collects their active-low interrupt lines, latches assertions into a pending register, and masks them with an enable register.
- Drives a single active-low nIRQ to the ARM core.
- The core identifies the winning source with a claim read and releases it with an end-of-interrupt (EOI) write, all over the same CS_N/RD_N/WR_N/Addr[11:0] peripheral bus.

---
 rtl/intr_pkg.sv | 17 +
 rtl/intr_prio_enc.sv | 20 ++
 rtl/intr_controller.sv | 121 ++++++++++++
 tb/tb_intr_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared constants and state encoding for the interrupt controller.
package intr_pkg;

  localparam logic [11:0] ADDR_ENABLE  = 12'h000;
  localparam logic [11:0] ADDR_PENDING = 12'h100;
  localparam logic [11:0] ADDR_CLAIM   = 12'h200;
  localparam logic [11:0] ADDR_EOI     = 12'h300;

  localparam int VALID_BIT = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module intr_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] active,
  output logic [3:0]         winner,
  output logic               any_active
);

  // Scan from the top down so the lowest index is written last.
  always_comb begin
    winner = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) winner = 4'(i);
    end
  end

  assign any_active = |active;

endmodule

// File: rtl/intr_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, enable mask,
// fixed priority, claim/EOI handshake and a registered active-low nIRQ.
module intr_controller
  import intr_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CS_N,
  input  logic               RD_N,
  input  logic               WR_N,
  input  logic [11:0]        Addr,
  input  logic [31:0]        DataIn,
  output logic [31:0]        DataOut,
  input  logic [NUM_SRC-1:0] IntrIn_N,
  output logic               nIRQ
);

  state_t               state, state_nxt;
  logic [NUM_SRC-1:0]   enable_r;
  logic [NUM_SRC-1:0]   pending_r;
  logic [NUM_SRC-1:0]   intr_prev;
  logic [31:0]          vector_r, vector_nxt;

  logic                 wr_en, rd_en;
  logic                 enable_wr, eoi_wr, claim_rd;
  logic [NUM_SRC-1:0]   edge_set, eoi_clr, active;
  logic [3:0]           winner;
  logic                 any_active;
  logic [31:0]          claim_word;
  logic                 unused_din;

  assign wr_en     = ~CS_N & ~WR_N;
  assign rd_en     = ~CS_N & ~RD_N;
  assign enable_wr = wr_en && (Addr == ADDR_ENABLE);
  assign eoi_wr    = wr_en && (Addr == ADDR_EOI);
  assign claim_rd  = rd_en && (Addr == ADDR_CLAIM);

  assign unused_din = ^DataIn[31:NUM_SRC];

  assign edge_set   = intr_prev & ~IntrIn_N;
  assign active     = pending_r & enable_r;
  assign claim_word = (32'd1 << VALID_BIT) | 32'(winner);

  intr_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .active     (active),
    .winner     (winner),
    .any_active (any_active)
  );

  // EOI clears only the bit that was claimed; a fresh edge on it still wins.
  always_comb begin
    eoi_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eoi_clr[i] = (state == SERVICE) && eoi_wr && (vector_r[3:0] == 4'(i));
    end
  end

  always_comb begin
    state_nxt  = state;
    vector_nxt = vector_r;
    case (state)
      IDLE: begin
        if (any_active) state_nxt = ASSERT;
      end
      ASSERT: begin
        if (!any_active) begin
          state_nxt = IDLE;
        end else if (claim_rd) begin
          state_nxt  = SERVICE;
          vector_nxt = claim_word;
        end
      end
      SERVICE: begin
        if (eoi_wr) begin
          state_nxt  = IDLE;
          vector_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      enable_r  <= '0;
      pending_r <= '0;
      intr_prev <= '1;
      vector_r  <= '0;
      nIRQ      <= 1'b1;
    end else begin
      state     <= state_nxt;
      vector_r  <= vector_nxt;
      nIRQ      <= (state_nxt != ASSERT);
      intr_prev <= IntrIn_N;
      pending_r <= (pending_r & ~eoi_clr) | edge_set;
      if (enable_wr) enable_r <= DataIn[NUM_SRC-1:0];
    end
  end

  // Claim reads only have a side effect in ASSERT; SERVICE replays the latched vector.
  always_comb begin
    DataOut = '0;
    if (rd_en) begin
      case (Addr)
        ADDR_ENABLE:  DataOut = 32'(enable_r);
        ADDR_PENDING: DataOut = 32'(pending_r);
        ADDR_CLAIM: begin
          if (state == ASSERT)       DataOut = claim_word;
          else if (state == SERVICE) DataOut = vector_r;
        end
        default: DataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
// Bench for intr_controller: directed vector table, hand sequences, random traffic vs model.
module tb_intr_controller;
  import intr_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         CS_N, RD_N, WR_N;
  logic [11:0]  Addr;
  logic [31:0]  DataIn;
  logic [31:0]  DataOut;
  logic [N-1:0] IntrIn_N;
  logic         nIRQ;

  int n_checks = 0;
  int n_errors = 0;

  intr_controller #(.NUM_SRC(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .CS_N     (CS_N),
    .RD_N     (RD_N),
    .WR_N     (WR_N),
    .Addr     (Addr),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .IntrIn_N (IntrIn_N),
    .nIRQ     (nIRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: bookkeeping of the interrupt handshake in plain terms.
  // phase 0 = no request outstanding, 1 = request raised to core, 2 = core is servicing
  logic [7:0]  m_en, m_pend, m_prev;
  int          m_phase;
  logic [31:0] m_vec;

  function automatic int lowest(input logic [7:0] x);
    for (int i = 0; i < 8; i++) if (x[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    logic       rd, wr;
    logic [7:0] edges, act, nxt;
    if (!reset) begin
      m_en = 8'h00; m_pend = 8'h00; m_prev = 8'hFF; m_phase = 0; m_vec = 32'h0;
    end else begin
      rd    = !CS_N && !RD_N;
      wr    = !CS_N && !WR_N;
      edges = m_prev & ~IntrIn_N;
      act   = m_pend & m_en;
      nxt   = m_pend;
      if (m_phase == 0) begin
        if (act != 0) m_phase = 1;
      end else if (m_phase == 1) begin
        if (act == 0) m_phase = 0;
        else if (rd && Addr == ADDR_CLAIM) begin
          m_vec   = 32'h8000_0000 + 32'(lowest(act));
          m_phase = 2;
        end
      end else if (wr && Addr == ADDR_EOI) begin
        nxt[m_vec[2:0]] = 1'b0;
        m_vec   = 32'h0;
        m_phase = 0;
      end
      m_pend = nxt | edges;
      if (wr && Addr == ADDR_ENABLE) m_en = DataIn[7:0];
      m_prev = IntrIn_N;
    end
  end

  function automatic logic [31:0] m_dout();
    if (CS_N || RD_N) return 32'h0;
    if (Addr == ADDR_ENABLE)  return {24'h0, m_en};
    if (Addr == ADDR_PENDING) return {24'h0, m_pend};
    if (Addr == ADDR_CLAIM) begin
      if (m_phase == 1) return 32'h8000_0000 + 32'(lowest(m_pend & m_en));
      if (m_phase == 2) return m_vec;
    end
    return 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [11:0] a, input logic [31:0] d,
                       input logic [7:0] in);
    {CS_N, RD_N, WR_N} = s;
    Addr     = a;
    DataIn   = d;
    IntrIn_N = in;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nirq_low(input string name);
    int k = 0;
    while (nIRQ !== 1'b0 && k < 10) begin
      step();
      k++;
    end
    chk(name, 32'(nIRQ), 32'h0);
  endtask

  localparam logic [2:0] RD = 3'b001;
  localparam logic [2:0] WR = 3'b010;
  localparam logic [2:0] ID = 3'b111;

  typedef struct {
    logic [2:0]  strb;
    logic [11:0] addr;
    logic [31:0] din;
    logic [7:0]  intr_n;
    logic [31:0] exp_dout;
    logic        exp_nirq;
  } vec_t;

  vec_t vecs[$];

  task automatic tv(input logic [2:0] s, input logic [11:0] a, input logic [31:0] d,
                    input logic [7:0] in, input logic [31:0] ed, input logic en);
    vec_t v;
    v.strb = s; v.addr = a; v.din = d; v.intr_n = in; v.exp_dout = ed; v.exp_nirq = en;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    drive(ID, 12'h0, 32'h0, 8'hFF);

    // reset state and single-source flow
    tv(RD, ADDR_ENABLE,  0, 8'hFF, 32'h0, 1);
    tv(RD, ADDR_PENDING, 0, 8'hFF, 32'h0, 1);
    tv(RD, ADDR_CLAIM,   0, 8'hFF, 32'h0, 1);
    tv(WR, ADDR_ENABLE,  32'h01, 8'hFF, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hFE, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hFE, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hFE, 32'h0, 0);
    tv(RD, ADDR_CLAIM,   0, 8'hFE, 32'h8000_0000, 0);
    tv(ID, 12'h0, 0, 8'hFE, 32'h0, 1);
    tv(RD, ADDR_CLAIM,   0, 8'hFE, 32'h8000_0000, 1);
    tv(WR, ADDR_EOI,     32'hDEAD_BEEF, 8'hFE, 32'h0, 1);
    tv(RD, ADDR_PENDING, 0, 8'hFF, 32'h0, 1);
    tv(RD, ADDR_CLAIM,   0, 8'hFF, 32'h0, 1);
    // priority: sources 5 and 2 together
    tv(WR, ADDR_ENABLE,  32'hFF, 8'hFF, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hDB, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hDB, 32'h0, 1);
    tv(RD, ADDR_CLAIM,   0, 8'hDB, 32'h8000_0002, 0);
    tv(WR, ADDR_EOI,     0, 8'hDB, 32'h0, 1);
    tv(RD, ADDR_PENDING, 0, 8'hDB, 32'h20, 1);
    tv(RD, ADDR_CLAIM,   0, 8'hDB, 32'h8000_0005, 0);
    tv(WR, ADDR_EOI,     0, 8'hDB, 32'h0, 1);
    tv(RD, ADDR_PENDING, 0, 8'hFF, 32'h0, 1);
    // masking
    tv(WR, ADDR_ENABLE,  32'h00, 8'hFF, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hF7, 32'h0, 1);
    tv(RD, ADDR_PENDING, 0, 8'hF7, 32'h08, 1);
    tv(ID, 12'h0, 0, 8'hF7, 32'h0, 1);
    tv(WR, ADDR_ENABLE,  32'h08, 8'hF7, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hF7, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hF7, 32'h0, 0);
    tv(RD, ADDR_CLAIM,   0, 8'hF7, 32'h8000_0003, 0);
    tv(WR, ADDR_EOI,     0, 8'hFF, 32'h0, 1);
    // disabling the source before the claim withdraws the request
    tv(ID, 12'h0, 0, 8'hF7, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hF7, 32'h0, 1);
    tv(WR, ADDR_ENABLE,  32'h00, 8'hF7, 32'h0, 0);
    tv(ID, 12'h0, 0, 8'hF7, 32'h0, 0);
    tv(RD, ADDR_PENDING, 0, 8'hF7, 32'h08, 1);
    tv(WR, ADDR_ENABLE,  32'hFF, 8'hFF, 32'h0, 1);
    tv(ID, 12'h0, 0, 8'hFF, 32'h0, 1);
    tv(RD, ADDR_CLAIM,   0, 8'hFF, 32'h8000_0003, 0);
    tv(WR, ADDR_EOI,     0, 8'hFF, 32'h0, 1);
    tv(RD, ADDR_PENDING, 0, 8'hFF, 32'h0, 1);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].strb, vecs[i].addr, vecs[i].din, vecs[i].intr_n);
      @(negedge clk);
      chk($sformatf("vec%0d_dout", i), DataOut, vecs[i].exp_dout);
      chk($sformatf("vec%0d_nirq", i), 32'(nIRQ), 32'(vecs[i].exp_nirq));
      step();
    end

    // edge on source 1 in the same cycle as its EOI keeps it pending
    drive(ID, 12'h0, 0, 8'hFD);
    step();
    wait_nirq_low("col_assert");
    drive(RD, ADDR_CLAIM, 0, 8'hFD);
    @(negedge clk);
    chk("col_claim", DataOut, 32'h8000_0001);
    step();
    drive(ID, 12'h0, 0, 8'hFF);
    step();
    drive(WR, ADDR_EOI, 0, 8'hFD);
    step();
    drive(RD, ADDR_PENDING, 0, 8'hFD);
    @(negedge clk);
    chk("col_pending", DataOut, 32'h02);
    chk("col_nirq_idle", 32'(nIRQ), 32'h1);
    step();
    drive(ID, 12'h0, 0, 8'hFD);
    @(negedge clk);
    chk("col_reassert", 32'(nIRQ), 32'h0);
    step();
    drive(RD, ADDR_CLAIM, 0, 8'hFD);
    @(negedge clk);
    chk("col_claim2", DataOut, 32'h8000_0001);
    step();
    drive(WR, ADDR_EOI, 0, 8'hFF);
    step();

    // reset in the middle of servicing source 0
    drive(ID, 12'h0, 0, 8'hFE);
    step();
    wait_nirq_low("rst_assert");
    drive(RD, ADDR_CLAIM, 0, 8'hFE);
    @(negedge clk);
    chk("rst_claim", DataOut, 32'h8000_0000);
    step();
    drive(ID, 12'h0, 0, 8'hFF);
    reset = 1'b0;
    step();
    reset = 1'b1;
    drive(RD, ADDR_PENDING, 0, 8'hFF);
    @(negedge clk);
    chk("rst_pending", DataOut, 32'h0);
    chk("rst_nirq", 32'(nIRQ), 32'h1);
    step();
    drive(RD, ADDR_CLAIM, 0, 8'hFF);
    @(negedge clk);
    chk("rst_claim_idle", DataOut, 32'h0);
    step();
    drive(RD, ADDR_ENABLE, 0, 8'hFF);
    @(negedge clk);
    chk("rst_enable", DataOut, 32'h0);
    step();

    // random bus traffic and interrupt lines against the model
    for (int c = 0; c < 3000; c++) begin
      logic [7:0]  flips;
      logic [11:0] a;
      int          sel;
      reset = ($urandom_range(0, 299) != 0);
      CS_N  = ($urandom_range(0, 3) == 0);
      RD_N  = ($urandom_range(0, 1) == 0);
      WR_N  = ($urandom_range(0, 2) != 0);
      sel   = $urandom_range(0, 5);
      case (sel)
        0: a = ADDR_ENABLE;
        1: a = ADDR_PENDING;
        2, 3: a = ADDR_CLAIM;
        4: a = ADDR_EOI;
        default: a = 12'($urandom);
      endcase
      Addr   = a;
      DataIn = $urandom;
      flips  = 8'h00;
      for (int b = 0; b < 8; b++) flips[b] = ($urandom_range(0, 5) == 0);
      IntrIn_N = IntrIn_N ^ flips;
      @(negedge clk);
      chk($sformatf("rnd%0d_dout", c), DataOut, m_dout());
      chk($sformatf("rnd%0d_nirq", c), 32'(nIRQ), (m_phase == 1) ? 32'h0 : 32'h1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
